audio_sample_packet_assembler: RTL
==================================

Name: audio_sample_packet_assembler

Overview:
- Audio-domain front end that groups incoming multi-channel PCM samples into HDMI Audio Sample Packet payloads.
- Supports layout 0 (2 channels, up to 4 samples per packet) and layout 1 (up to 8 channels, 1 sample per packet).
- Tracks the IEC 60958 192-frame block and produces per-subpacket B, C and parity bits.
- Completed payloads go to a 2-deep output queue with valid/ready handshake, feeding the clock-domain crossing toward the pixel-side packet scheduler.

Parameters:
- AUDIO_BIT_WIDTH, 16, PCM sample width, 16..24.
- CHANNELS, 2, channel count, one of 2/4/6/8; 2 selects layout 0, otherwise layout 1.
- CHANNEL_STATUS, 192'd0, IEC 60958 channel-status block; bit i is the C bit for frame i.

Ports:
- clk_audio  in  1  audio sample clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  one sample set present; always accepted, no backpressure.
- in_sample  in  CHANNELS*AUDIO_BIT_WIDTH  channel c at bits [c*W +: W].
- flush  in  1  layout 0 only: close a partially filled packet.
- out_valid  out  1  head of queue holds a packet.
- out_ready  in  1  consumer accepts the head packet.
- out_layout  out  1  0 = layout 0, 1 = layout 1; constant from CHANNELS.
- out_sample  out  4*2*24  subpacket k, channel j at bits [(2k+j)*24 +: 24]; left-justified.
- out_present  out  4  per-subpacket present flags.
- out_b  out  4  per-subpacket start-of-block flag.
- out_cs  out  4  per-subpacket channel-status bit.
- out_parity  out  8  even parity per subpacket/channel, same index as out_sample.
- overflow_count  out  16  saturating count of dropped packets.

Behaviour:
- Reset values: out_valid=0, out_* payload=0, overflow_count=0. Frame counter=0, fill index=0, queue empty. Reset mid-operation discards the assembler and both queue entries.
- Sample formatting: each sample is left-justified to 24 bits with zero LSBs.
- Parity: even parity over {C, U=0, V=0, sample[23:0]}. Parity=0 for non-present subpackets and unused channels.
- Frame counter: 8 bits, counts 0..191, wraps 191->0.
- Frame counter advance: +1 per accepted in_valid, including samples whose packet is later dropped, so IEC block timing is preserved.
- B/C per sample: B = (frame counter == 0); C = CHANNEL_STATUS[frame counter]; both sampled before the increment.
- Layout 0, capture: in_valid writes the assembler slot at fill index 0..3, storing sample, B, C and parity. Fill index 3 -> completes with present=4'b1111; fill index returns to 0.
- Layout 0, flush:
  - flush with fill index>0 completes the packet with present bits = filled indices only, e.g. 2 samples -> 4'b0011.
  - flush and in_valid in the same cycle: the sample is stored first, then the packet closes.
  - flush with an empty assembler is a no-op.
- Layout 1:
  - Every in_valid completes one packet. Subpacket k carries channels 2k and 2k+1.
  - present = (1<<(CHANNELS/2))-1; remaining subpackets are zero.
  - All present subpackets share the same B and C. flush is ignored.
- Queue: 2 entries. Completion pushes; out_valid && out_ready pops. Head fields are stable while out_valid && !out_ready.
- Latency: a completed packet is visible at out_valid one cycle after the completing in_valid/flush edge.
- Full queue: completing while full with no pop in the same cycle drops the new packet and increments overflow_count (saturates at 16'hFFFF). Push and pop in the same cycle while full: the push is accepted, no drop.
- The assembler keeps accepting samples after a drop.

Decomposition:
- Package audio_pkg holds:
  - IEC_FRAMES_PER_BLOCK=192.
  - Typedef asp_payload_t: sample, present, b, cs, parity fields.
  - Function left_justify24(sample, width).
  - Function iec_parity(sample24, c).
- One sub-module: asp_payload_queue, a 2-entry synchronous valid/ready FIFO parametrised on payload width, with push/pop/full.

Test Plan:
- CHANNELS=2, W=16: 4 samples 16'h1234.. -> one packet, present=4'b1111, out_sample[0]=24'h123400, out_b=4'b0001 on the first packet after reset.
- CHANNELS=2: 194 consecutive samples -> out_b bit set for frame 0 and again at sample 192 (packet 48, subpacket 0); out_cs matches CHANNEL_STATUS bits.
- CHANNELS=2: 2 samples then flush -> present=4'b0011, subpackets 2-3 zero, parity 0. A following flush alone produces no packet.
- CHANNELS=6, W=24: one in_valid -> layout=1, present=4'b0111, channel 5 in subpacket 2 bits [47:24], parity correct for 24'hFFFFFF with C=1.
- out_ready=0, 12 samples (3 packets) -> 2 queued, overflow_count=1. Then out_ready=1 with a packet completing on the same cycle as a pop when full -> no further drop.
- Reset asserted with 2 queued packets and fill index 2 -> out_valid=0 next cycle, frame counter restarts (next B=1).

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and helpers for the HDMI audio sample packet assembler.
package audio_pkg;

    // IEC 60958 block length in frames.
    localparam int IEC_FRAMES_PER_BLOCK = 192;

    // One Audio Sample Packet payload: 4 subpackets x 2 channels of 24-bit samples.
    typedef struct packed {
        logic [191:0] sample;   // subpacket k, channel j at [(2k+j)*24 +: 24]
        logic [3:0]   present;  // subpacket carries data
        logic [3:0]   b;        // start-of-block flag per subpacket
        logic [3:0]   cs;       // channel-status bit per subpacket
        logic [7:0]   parity;   // even parity per subpacket/channel
    } asp_payload_t;

    // Left-justify a width-bit sample (held in the LSBs) into 24 bits, zero-filling the LSBs.
    function automatic logic [23:0] left_justify24(input logic [23:0] sample, input int width);
        return sample << (24 - width);
    endfunction

    // Even parity over {C, U=0, V=0, sample}.
    function automatic logic iec_parity(input logic [23:0] sample24, input logic c);
        return ^{c, 1'b0, 1'b0, sample24};
    endfunction

endpackage

// File: rtl/asp_payload_queue.sv
// Two-entry synchronous valid/ready FIFO. A push while full is only accepted
// when a pop happens on the same edge; otherwise the caller treats it as dropped.
module asp_payload_queue #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             pop_s;
    logic             push_ok_s;

    assign pop_s     = pop && (count_q != 2'd0);
    assign push_ok_s = push && ((count_q != 2'd2) || pop_s);
    assign valid     = (count_q != 2'd0);
    assign full      = (count_q == 2'd2);
    assign head      = head_q;

    // Next-state for the head/tail entries; the tail is kept zero whenever it is unoccupied.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push_ok_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                tail_d  = '0;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Queue state register with synchronous reset that empties both entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/audio_sample_packet_assembler.sv
// Groups PCM sample sets into HDMI Audio Sample Packet payloads, tracks the
// IEC 60958 192-frame block for B/C bits and queues finished payloads.
module audio_sample_packet_assembler
    import audio_pkg::*;
#(
    parameter int           AUDIO_BIT_WIDTH = 16,
    parameter int           CHANNELS        = 2,
    parameter logic [191:0] CHANNEL_STATUS  = 192'd0
) (
    input  logic                                 clk_audio,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0]  in_sample,
    input  logic                                 flush,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_layout,
    output logic [191:0]                         out_sample,
    output logic [3:0]                           out_present,
    output logic [3:0]                           out_b,
    output logic [3:0]                           out_cs,
    output logic [7:0]                           out_parity,
    output logic [15:0]                          overflow_count
);

    localparam logic       LAYOUT1    = (CHANNELS != 2);
    localparam int         PW         = $bits(asp_payload_t);
    localparam logic [7:0] LAST_FRAME = 8'(IEC_FRAMES_PER_BLOCK - 1);
    localparam logic [3:0] L1_PRESENT = 4'((1 << (CHANNELS / 2)) - 1);

    logic [7:0]   frame_q, frame_d;
    logic [1:0]   fill_q, fill_d;
    asp_payload_t asm_q, asm_d;
    logic [15:0]  overflow_q, overflow_d;
    asp_payload_t slot_s;
    asp_payload_t pkt_s;
    asp_payload_t head_s;
    logic         complete_s;
    logic         drop_s;
    logic         b_s;
    logic         c_s;
    logic         q_valid_s;
    logic         q_full_s;
    logic         pop_s;
    logic [23:0]  ch_lj_s [8];

    // Left-justified view of every channel; channels beyond CHANNELS read as zero.
    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < CHANNELS) begin : g_used
            assign ch_lj_s[c] = left_justify24(24'(in_sample[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]),
                                               AUDIO_BIT_WIDTH);
        end else begin : g_unused
            assign ch_lj_s[c] = 24'd0;
        end
    end

    assign pop_s = q_valid_s && out_ready;

    // Frame counting, slot filling, packet completion and overflow accounting.
    always_comb begin
        frame_d    = frame_q;
        fill_d     = fill_q;
        asm_d      = asm_q;
        overflow_d = overflow_q;
        slot_s     = asm_q;
        pkt_s      = '0;
        complete_s = 1'b0;
        drop_s     = 1'b0;
        // B and C belong to the frame the sample lands in, before the counter moves on.
        b_s = (frame_q == 8'd0);
        c_s = CHANNEL_STATUS[frame_q];

        if (in_valid) begin
            frame_d = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
        end else begin
            frame_d = frame_q;
        end

        if (LAYOUT1) begin
            // Layout 1: one sample set fills subpackets 0..CHANNELS/2-1 at once.
            complete_s = in_valid;
            for (int k = 0; k < 4; k++) begin
                if (L1_PRESENT[k]) begin
                    pkt_s.sample[k*48 +: 24]      = ch_lj_s[2*k];
                    pkt_s.sample[k*48 + 24 +: 24] = ch_lj_s[2*k+1];
                    pkt_s.present[k]              = 1'b1;
                    pkt_s.b[k]                    = b_s;
                    pkt_s.cs[k]                   = c_s;
                    pkt_s.parity[2*k]             = iec_parity(ch_lj_s[2*k], c_s);
                    pkt_s.parity[2*k+1]           = iec_parity(ch_lj_s[2*k+1], c_s);
                end else begin
                    pkt_s.present[k] = 1'b0;
                end
            end
        end else begin
            // Layout 0: the new sample (if any) goes into slot fill_q before a possible close.
            if (in_valid) begin
                for (int k = 0; k < 4; k++) begin
                    if (fill_q == 2'(k)) begin
                        slot_s.sample[k*48 +: 24]      = ch_lj_s[0];
                        slot_s.sample[k*48 + 24 +: 24] = ch_lj_s[1];
                        slot_s.present[k]              = 1'b1;
                        slot_s.b[k]                    = b_s;
                        slot_s.cs[k]                   = c_s;
                        slot_s.parity[2*k]             = iec_parity(ch_lj_s[0], c_s);
                        slot_s.parity[2*k+1]           = iec_parity(ch_lj_s[1], c_s);
                    end else begin
                        slot_s.present[k] = asm_q.present[k];
                    end
                end
                complete_s = (fill_q == 2'd3) || flush;
            end else begin
                slot_s     = asm_q;
                complete_s = flush && (fill_q != 2'd0);
            end
            pkt_s = slot_s;

            if (complete_s) begin
                asm_d  = '0;
                fill_d = 2'd0;
            end else if (in_valid) begin
                asm_d  = slot_s;
                fill_d = fill_q + 2'd1;
            end else begin
                asm_d  = asm_q;
                fill_d = fill_q;
            end
        end

        // A completion that finds the queue full and not draining is lost.
        drop_s = complete_s && q_full_s && !pop_s;
        if (drop_s && (overflow_q != 16'hFFFF)) begin
            overflow_d = overflow_q + 16'd1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Assembler state register; reset discards any partially filled packet.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            frame_q    <= 8'd0;
            fill_q     <= 2'd0;
            asm_q      <= '0;
            overflow_q <= 16'd0;
        end else begin
            frame_q    <= frame_d;
            fill_q     <= fill_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
        end
    end

    asp_payload_queue #(
        .WIDTH (PW)
    ) u_queue (
        .clk       (clk_audio),
        .reset     (reset),
        .push      (complete_s),
        .push_data (pkt_s),
        .pop       (pop_s),
        .valid     (q_valid_s),
        .full      (q_full_s),
        .head      (head_s)
    );

    assign out_valid      = q_valid_s;
    assign out_layout     = LAYOUT1;
    assign out_sample     = head_s.sample;
    assign out_present    = head_s.present;
    assign out_b          = head_s.b;
    assign out_cs         = head_s.cs;
    assign out_parity     = head_s.parity;
    assign overflow_count = overflow_q;

endmodule
